// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared constants and helpers for the RAM arbiter
//
// Purpose : statistics counter width and the round-robin pointer wrap helper
//           used by rr_arbiter and ram_arbiter.
// Ports   : none (package).
package ram_arb_pkg;

    localparam int STAT_WIDTH = 32;

    // Pointer that follows a winner: one past it, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with its own priority pointer
//
// Purpose : grants the first requesting bit at or after the pointer, searching
//           upward with wrap. The pointer moves to winner+1 on a grant and holds
//           otherwise. Grants are suppressed while rst is high.
// Ports   : clk, rst (sync, active-high)
//           req[N]       - request vector
//           grant[N]     - one-hot grant (all zero when nothing requests)
//           grant_idx    - index of the granted bit (0 when no grant)
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        if (!rst) begin
            for (int off = 0; off < N; off++) begin
                cand = IDX_W'((int'(ptr_q) + off) % N);
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = IDX_W'(rr_next(32'(grant_idx), N));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one simple dual-port RAM among NUM_REQ requesters
//
// Purpose : independent round-robin arbitration of a write pool and a read pool
//           each cycle; drives the RAM write port and combinational read port,
//           returns registered read data one cycle after the read grant.
// Option  : RAM_ARB_STATS_EN adds saturating accept counters stat_rd_cnt and
//           stat_wr_cnt (STAT_WIDTH bits, cleared by rst).
// Ports   : clk, rst (sync, active-high)
//           req_valid/req_we[NUM_REQ], req_addr/req_wdata (flattened slices)
//           req_ready[NUM_REQ] - grant, transfer on valid & ready
//           rsp_valid[NUM_REQ], rsp_rdata - read response, one cycle after grant
//           ram_waddr, ram_wen, ram_wdata - RAM write port
//           ram_raddr, ram_rdata          - RAM read port (combinational data)
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [ADDR_WIDTH-1:0]            ram_waddr,
    output logic [ADDR_WIDTH-1:0]            ram_raddr,
    output logic                             ram_wen,
    output logic [DATA_WIDTH-1:0]            ram_wdata,
    input  logic [DATA_WIDTH-1:0]            ram_rdata
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]            stat_rd_cnt,
    output logic [STAT_WIDTH-1:0]            stat_wr_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    wr_pool;
    logic [NUM_REQ-1:0]    rd_pool;
    logic [NUM_REQ-1:0]    wr_grant;
    logic [NUM_REQ-1:0]    rd_grant;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  wr_any;
    logic                  rd_any;

    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [ADDR_WIDTH-1:0] raddr_d;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [NUM_REQ-1:0]    rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;

    // A requester is re-pooled every cycle from its current we bit.
    assign wr_pool = req_valid & req_we;
    assign rd_pool = req_valid & ~req_we;

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (wr_pool),
        .grant     (wr_grant),
        .grant_idx (wr_idx)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (rd_pool),
        .grant     (rd_grant),
        .grant_idx (rd_idx)
    );

    assign wr_any    = |wr_grant;
    assign rd_any    = |rd_grant;
    assign req_ready = wr_grant | rd_grant;

    always_comb begin
        raddr_d = raddr_q;
        if (rd_any) begin
            raddr_d = req_addr[32'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
        ram_raddr = raddr_d;

        ram_wen = wr_any;
        if (wr_any) begin
            ram_waddr = req_addr[32'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ram_wdata = req_wdata[32'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            // Idle write address differs from the read address so the RAM's
            // write-to-read bypass can never fire on stale write data.
            ram_waddr = raddr_d ^ ADDR_WIDTH'(1);
            ram_wdata = '0;
        end

        rsp_valid_d = rd_grant;
        rsp_rdata_d = rd_any ? ram_rdata : rsp_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raddr_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            raddr_q     <= raddr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // A response in flight when rst rises is dropped in that same cycle.
    assign rsp_valid = rsp_valid_q & {NUM_REQ{~rst}};
    assign rsp_rdata = rsp_rdata_q;

`ifdef RAM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] rd_cnt_q;
    logic [STAT_WIDTH-1:0] rd_cnt_d;
    logic [STAT_WIDTH-1:0] wr_cnt_q;
    logic [STAT_WIDTH-1:0] wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_any && !(&rd_cnt_q)) begin
            rd_cnt_d = rd_cnt_q + STAT_WIDTH'(1);
        end
        if (wr_any && !(&wr_cnt_q)) begin
            wr_cnt_d = wr_cnt_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign stat_rd_cnt = rd_cnt_q;
    assign stat_wr_cnt = wr_cnt_q;
`endif

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one simple dual-port RAM (one write port, one combinational read port, write-to-read bypass when addresses match) among NUM_REQ requesters.
- Each cycle it runs two independent round-robin arbitrations: one write winner and one read winner.
- It drives the RAM ports and returns registered read data to the winning requester one cycle later.
- It sits directly in front of the RAM instance; requesters never touch RAM ports.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ADDR_WIDTH, 8, RAM address width (>=1)
DATA_WIDTH, 32, RAM data width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  request pending, bit i = requester i
req_we  in  NUM_REQ  1 = write request, 0 = read request
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; slice i = requester i address
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
req_ready  out  NUM_REQ  grant; a transfer occurs when valid & ready
rsp_valid  out  NUM_REQ  read data valid for requester i
rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters
ram_waddr  out  ADDR_WIDTH  to RAM write address
ram_raddr  out  ADDR_WIDTH  to RAM read address
ram_wen  out  1  to RAM write enable
ram_wdata  out  DATA_WIDTH  to RAM write data
ram_rdata  in  DATA_WIDTH  from RAM read data (combinational)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- During rst:
  - req_ready = 0, ram_wen = 0.
  - Registers clear: rsp_valid = 0, rsp_rdata = 0, wr_ptr = 0, rd_ptr = 0.
- Arbiter pools:
  - Write pool = req_valid & req_we.
  - Read pool = req_valid & ~req_we.
- Arbitration (combinational from pool and pointer):
  - Each pool grants the first set bit at or after its pointer, searching upward with wrap from NUM_REQ-1 to 0.
  - At most one write grant and one read grant per cycle.
  - req_ready is the OR of the two grants.
- Pointer update: on a granted cycle, the pool's pointer becomes winner+1 mod NUM_REQ. With no grant, the pointer holds.
- Write path (same cycle as grant):
  - ram_wen = 1, ram_waddr and ram_wdata taken from the winner's slices.
  - The RAM commits the write at that clock edge.
- Read path (same cycle as grant):
  - ram_raddr = winner's address.
  - At the clock edge: rsp_rdata <= ram_rdata, and rsp_valid <= one-hot of the winner.
  - Latency is exactly 1 cycle from accept to rsp_valid. rsp_valid is high for 1 cycle only.
- Simultaneous read and write to the same address in one cycle: the RAM bypass returns the new write data (write-first). This is required behaviour.
- No write winner:
  - ram_wen = 0, ram_wdata = 0.
  - ram_waddr = ram_raddr with the LSB inverted. This guarantees no false bypass.
- No read winner: ram_raddr holds its last granted value (registered copy). rsp_valid = 0 next cycle.
- Requester contract: a requester may hold req_valid until granted. The arbiter never drops or reorders a granted transfer. A requester with we=0 and we=1 toggling is re-pooled every cycle.
- Fairness: a continuously-requesting requester waits at most NUM_REQ-1 grants of its pool.
- Reset mid-operation: an in-flight read response is discarded (rsp_valid = 0 the cycle after rst). RAM contents are not touched by this block.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_rd_cnt and stat_wr_cnt, each STAT_WIDTH bits.
  - They count accepted reads and writes, saturate at all-ones, and clear on rst.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package ram_arb_pkg:
  - localparam STAT_WIDTH = 32.
  - Function rr_next(ptr, n) for pointer wrap.
- Sub-module rr_arbiter (params N): inputs clk, rst, req[N]; outputs grant one-hot [N] and grant_idx.
  - Contains the pointer register.
  - Instantiated twice: read pool and write pool.

Test Plan:
1. Reset: hold rst 3 cycles with all req_valid=1 -> req_ready=0, ram_wen=0, rsp_valid=0, rsp_rdata=0 every cycle.
2. Single write then read: req0 writes addr 0x10 data 0xCAFE0001; next cycle req0 reads 0x10 -> rsp_valid=0b0001 one cycle later, rsp_rdata=0xCAFE0001.
3. Round robin: all 4 requesters read continuously from reset -> grant order 0,1,2,3,0 with one grant per cycle, and each rsp_valid bit appears 1 cycle after its grant.
4. Concurrent pools: req1 writes 0x20=0x55 while req2 reads 0x20 the same cycle -> both ready=1, and req2 receives 0x55 (write-first).
5. No false bypass: req3 reads 0x07 after the RAM holds 0x07=0xA5, with no writer -> ram_waddr=0x06, ram_wen=0, rsp_rdata=0xA5.
6. Reset mid-read: read granted in cycle N, rst=1 in cycle N+1 -> rsp_valid=0 in N+1 and both pointers return to 0. With RAM_ARB_STATS_EN defined, counters read 0 after rst.
